// File: rtl/lsu_ctrl_pkg.sv
// Memory opcode constants and decode helpers shared by the load/store unit.
// Pure declarations: no latency, no flow control.
package lsu_ctrl_pkg;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2b;

  function automatic logic is_load(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replicated data, load extraction/extension, misalign check.
// Purely combinational, zero latency, no flow control.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  adr,
  input  logic [31:0] rdata2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [31:0] sh;

  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    ldata    = 32'h0;
    misalign = 1'b0;
    // Right-justify the addressed lane; halves are only used when adr[0] is 0.
    sh       = rdata >> {adr, 3'b000};
    case (op)
      LW: begin
        be       = 4'b1111;
        ldata    = rdata;
        misalign = |adr;
      end
      LH, LHU: begin
        be       = 4'b1111;
        ldata    = (op == LH) ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        misalign = adr[0];
      end
      LB, LBU: begin
        be    = 4'b1111;
        ldata = (op == LB) ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      end
      SW: begin
        be       = 4'b1111;
        wdata    = rdata2;
        misalign = |adr;
      end
      SH: begin
        be       = adr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rdata2[15:0]}};
        misalign = adr[0];
      end
      SB: begin
        be    = 4'b0001 << adr;
        wdata = {4{rdata2[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one handshaked memory access per instruction, Stall held until done.
// Store 2 cycles, load 3 cycles minimum; waits on MemGnt/MemRvalid add cycles, loads abort after TIMEOUT.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic [31:0] Wdata,
  output logic        WdataValid,
  output logic        Misalign,
  output logic        BusErr,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAdr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWdata,
  input  logic        MemGnt,
  input  logic        MemRvalid,
  input  logic [31:0] MemRdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] TO     = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [5:0]  op_q;
  logic [1:0]  adr_q;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        idle;
  logic        mem_op;
  logic        accept;
  logic [5:0]  sel_op;
  logic [1:0]  sel_adr;
  logic [3:0]  be;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        mis;
  logic        unused_ins;

  assign unused_ins = ^Ins[25:0];

  assign idle    = (state == S_IDLE);
  assign mem_op  = is_mem(Ins[31:26]);
  // The aligner sees the live instruction in IDLE and the latched one afterwards.
  assign sel_op  = idle ? Ins[31:26] : op_q;
  assign sel_adr = idle ? Result[1:0] : adr_q;
  assign cnt_nxt = cnt + 8'd1;

  lsu_align u_align (
    .op       (sel_op),
    .adr      (sel_adr),
    .rdata2   (Rdata2),
    .rdata    (MemRdata),
    .be       (be),
    .wdata    (st_data),
    .ldata    (ld_data),
    .misalign (mis)
  );

  assign accept = idle & Valid & mem_op & ~mis;
  // Gated by RST so the combinational term is also quiet while reset is held.
  assign Stall  = RST & (accept | (state == S_REQ) | (state == S_RESP));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      op_q       <= 6'h0;
      adr_q      <= 2'b00;
      cnt        <= 8'h0;
      Wdata      <= 32'h0;
      WdataValid <= 1'b0;
      Misalign   <= 1'b0;
      BusErr     <= 1'b0;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAdr     <= 32'h0;
      MemBe      <= 4'h0;
      MemWdata   <= 32'h0;
    end else begin
      WdataValid <= 1'b0;
      Misalign   <= 1'b0;
      BusErr     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Valid && mem_op) begin
            if (mis) begin
              Misalign <= 1'b1;
            end else begin
              op_q     <= Ins[31:26];
              adr_q    <= Result[1:0];
              MemAdr   <= {Result[31:2], 2'b00};
              MemBe    <= be;
              MemWdata <= st_data;
              MemWe    <= is_store(Ins[31:26]);
              MemReq   <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (MemGnt) begin
            MemReq <= 1'b0;
            cnt    <= 8'h0;
            state  <= MemWe ? S_DONE : S_RESP;
          end
        end
        S_RESP: begin
          if (MemRvalid) begin
            Wdata      <= ld_data;
            WdataValid <= 1'b1;
            state      <= S_DONE;
          end else if (cnt_nxt == TO) begin
            Wdata  <= 32'h0;
            BusErr <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed cycle-by-cycle vectors for lsu_ctrl (TIMEOUT=4) plus hand-written grant-wait and extension sequences.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Valid;
  logic [31:0] Ins, Result, Rdata2;
  logic        Stall, WdataValid, Misalign, BusErr;
  logic [31:0] Wdata;
  logic        MemReq, MemWe;
  logic [31:0] MemAdr, MemWdata;
  logic [3:0]  MemBe;
  logic        MemGnt, MemRvalid;
  logic [31:0] MemRdata;

  always #5 CLK = ~CLK;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Stall(Stall), .Wdata(Wdata), .WdataValid(WdataValid), .Misalign(Misalign), .BusErr(BusErr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAdr(MemAdr), .MemBe(MemBe), .MemWdata(MemWdata),
    .MemGnt(MemGnt), .MemRvalid(MemRvalid), .MemRdata(MemRdata)
  );

  typedef struct packed {
    logic        stall, req, we;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        wv, mis, berr;
    logic [31:0] wd;
  } obs_t;

  typedef struct {
    logic        rst, valid;
    logic [5:0]  op;
    logic [31:0] res, rd2;
    logic        gnt, rv;
    logic [31:0] mrd;
    obs_t        exp;
    logic        wdc;
  } vec_t;

  vec_t        tbl[$];
  int          errors = 0;
  int          checks = 0;
  logic        h_we;
  logic [31:0] h_adr, h_mwd;
  logic [3:0]  h_be;

  // Registered request fields expected to persist across the following rows.
  task automatic held(input logic we, input logic [31:0] adr, input logic [3:0] be, input logic [31:0] mwd);
    h_we = we; h_adr = adr; h_be = be; h_mwd = mwd;
  endtask

  task automatic add(input logic rst, input logic valid, input logic [5:0] op, input logic [31:0] res,
                     input logic [31:0] rd2, input logic gnt, input logic rv, input logic [31:0] mrd,
                     input logic stall, input logic req, input logic wv, input logic mis,
                     input logic berr, input logic wdc, input logic [31:0] wd);
    vec_t v;
    v.rst = rst; v.valid = valid; v.op = op; v.res = res; v.rd2 = rd2;
    v.gnt = gnt; v.rv = rv; v.mrd = mrd; v.wdc = wdc;
    v.exp = '{stall: stall, req: req, we: h_we, adr: h_adr, be: h_be, mwd: h_mwd,
              wv: wv, mis: mis, berr: berr, wd: wd};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    obs_t got, exp;
    RST = v.rst; Valid = v.valid; Ins = {v.op, 26'h0}; Result = v.res; Rdata2 = v.rd2;
    MemGnt = v.gnt; MemRvalid = v.rv; MemRdata = v.mrd;
    @(negedge CLK);
    got = {Stall, MemReq, MemWe, MemAdr, MemBe, MemWdata, WdataValid, Misalign, BusErr, Wdata};
    exp = v.exp;
    if (!v.wdc) begin
      got.wd = 32'h0;
      exp.wd = 32'h0;
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d got=%h exp=%h", idx, got, exp);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int waited;
    RST = 1'b0; Valid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
    MemGnt = 1'b0; MemRvalid = 1'b0; MemRdata = '0;

    // rst valid op res rd2 gnt rv mrd | stall req wv mis berr wdc wd
    held(0, 32'h0, 4'h0, 32'h0);
    add(0, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 32'h0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    // SB at 0x13, zero-wait grant
    add(1, 1, SB, 32'h13, 32'hAABBCCDD, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    held(1, 32'h10, 4'b1000, 32'hDDDDDDDD);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    // LB / LBU at 0x21, LHU at 0x22, back to back
    add(1, 1, LB, 32'h21, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    held(0, 32'h20, 4'hF, 32'h0);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 1, 32'h00008000,      1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 1, 0, 0, 1, 32'hFFFFFF80);
    add(1, 1, LBU, 32'h21, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 1, 32'h00008000,      1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 1, 0, 0, 1, 32'h00000080);
    add(1, 1, LHU, 32'h22, 0, 0, 0, 0,             1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 1, 32'hF00D0000,      1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 1, 0, 0, 1, 32'h0000F00D);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    // LW at 0x40: grant in c3, rvalid in c5, Stall c0..c5
    add(1, 1, LW, 32'h40, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    held(0, 32'h40, 4'hF, 32'h0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 1, 32'h12345678,      1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 1, 0, 0, 1, 32'h12345678);
    // stray grant/rvalid in IDLE leave everything alone
    add(1, 0, 6'h0, 0, 0, 1, 1, 32'hDEADBEEF,      0, 0, 0, 0, 0, 1, 32'h12345678);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    // misaligned LW 0x42, SH 0x41, then a non-memory opcode
    add(1, 1, LW, 32'h42, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, SH, 32'h41, 32'h55556666, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 6'h00, 32'h40, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    // LW 0x80 never answered: BusErr TIMEOUT+1 cycles after grant
    add(1, 1, LW, 32'h80, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    held(0, 32'h80, 4'hF, 32'h0);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 1, 1, 32'h0);
    add(1, 1, SW, 32'h84, 32'hCAFEBABE, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    held(1, 32'h84, 4'hF, 32'hCAFEBABE);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
    // reset while in RESP, late rvalid dropped
    add(1, 1, LW, 32'h10, 0, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0);
    held(0, 32'h10, 4'hF, 32'h0);
    add(1, 0, 6'h0, 0, 0, 1, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    held(0, 32'h0, 4'h0, 32'h0);
    add(0, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 32'h0);
    add(0, 0, 6'h0, 0, 0, 0, 1, 32'hFFFFFFFF,      0, 0, 0, 0, 0, 1, 32'h0);
    add(1, 0, 6'h0, 0, 0, 0, 1, 32'hFFFFFFFF,      0, 0, 0, 0, 0, 1, 32'h0);
    add(1, 0, 6'h0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 32'h0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // SH at 0x42 with a three-cycle grant wait: request fields must stay put
    Valid = 1'b1; Ins = {SH, 26'h0}; Result = 32'h42; Rdata2 = 32'h1234BEEF;
    @(negedge CLK);
    chk("sh_accept_stall", Stall, 1);
    @(posedge CLK); #1;
    Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("sh_req_hold", {MemReq, MemWe, MemBe, MemWdata, MemAdr, Stall},
          {1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h40, 1'b1});
      @(posedge CLK); #1;
    end
    MemGnt = 1'b1;
    @(posedge CLK); #1;
    MemGnt = 1'b0;
    @(negedge CLK);
    chk("sh_done", {Stall, MemReq, WdataValid}, 3'b000);
    @(posedge CLK); #1;

    // LH at 0x02 picks the upper half and sign-extends it
    Valid = 1'b1; Ins = {LH, 26'h0}; Result = 32'h02; Rdata2 = 32'h0;
    @(posedge CLK); #1;
    Valid = 1'b0; MemGnt = 1'b1;
    @(posedge CLK); #1;
    MemGnt = 1'b0; MemRvalid = 1'b1; MemRdata = 32'h8001_0000;
    @(posedge CLK); #1;
    MemRvalid = 1'b0; MemRdata = 32'h0;
    waited = 0;
    while (!WdataValid && waited < 10) begin
      @(posedge CLK); #1;
      waited++;
    end
    chk("lh_wdata_valid", WdataValid, 1);
    chk("lh_sign_ext", Wdata, 32'hFFFF8001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator that sits between the execute stage and a handshaked data-memory port. It decodes the memory opcodes LW, LH, LHU, LB, LBU, SW, SH and SB. It issues one request per instruction with byte enables and replicated store data, and holds the pipeline (`Stall`) until the access completes. Load data is aligned and sign- or zero-extended and returned on `Wdata`. Misaligned accesses and memory timeouts are flagged instead of issued or hung.

## Interface
- `TIMEOUT`, 16: cycles to wait for `MemRvalid` after grant before aborting a load; legal range 2..255.
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Valid`  in  1  `Ins`, `Result` and `Rdata2` hold a live instruction; sampled only in IDLE.
- `Ins`  in  32  instruction; opcode is `Ins[31:26]`.
- `Result`  in  32  ALU effective address (byte address).
- `Rdata2`  in  32  store source register.
- `Stall`  out  1  freeze upstream stages.
- `Wdata`  out  32  extended load result; valid only while `WdataValid` is high.
- `WdataValid`  out  1  one-cycle pulse: load result ready for write-back.
- `Misalign`  out  1  one-cycle pulse: unaligned access was dropped.
- `BusErr`  out  1  one-cycle pulse: load timed out.
- `MemReq`  out  1  request valid; held until granted.
- `MemWe`  out  1  1 = store, 0 = load.
- `MemAdr`  out  32  word-aligned address, `{Result[31:2],2'b00}`.
- `MemBe`  out  4  byte enables, little-endian (bit0 = byte at `Adr[1:0]`=0).
- `MemWdata`  out  32  store data.
- `MemGnt`  in  1  request accepted this cycle.
- `MemRvalid`  in  1  load data valid.
- `MemRdata`  in  32  load data word.

## Operation
- **States:** IDLE, REQ, RESP, DONE.
- **IDLE:** when `Valid` is high and the opcode is a memory op:
  - If aligned, latch the opcode, `Adr[1:0]`, `MemAdr`, `MemBe` and `MemWdata`, then go to REQ.
  - If misaligned (word with `Adr[1:0]`≠0, half with `Adr[0]`≠0), stay in IDLE and pulse `Misalign` in the next cycle.
  - Non-memory opcodes are ignored.
- **REQ:** `MemReq`=1 with stable `MemAdr`, `MemWe`, `MemBe` and `MemWdata` until `MemGnt`.
  - On `MemGnt`, a store goes to DONE and a load goes to RESP with the timeout counter cleared.
- **RESP:** the counter increments each cycle.
  - On `MemRvalid`, register the extended data and go to DONE.
  - If the counter reaches `TIMEOUT` first, pulse `BusErr`, set `Wdata`=0 and go to IDLE.
- **DONE:** one cycle. `Stall`=0; `WdataValid`=1 for loads only. Then go to IDLE.
- **Stall:** `(state∈{REQ,RESP}) | (state==IDLE & Valid & aligned mem op)`. Combinational on `Valid` in IDLE; this is the only combinational path to an output.
- **Store encoding:**
  - SW: `MemBe`=4'b1111, data=`Rdata2`.
  - SH: `MemBe`=`Adr[1]`?4'b1100:4'b0011, data=`{2{Rdata2[15:0]}}`.
  - SB: `MemBe`=1<<`Adr[1:0]`, data=`{4{Rdata2[7:0]}}`.
- **Load extraction:** select the byte or half at `Adr[1:0]` from `MemRdata`. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged. `MemBe` is 4'b1111 for all loads.
- **Unexpected responses:** `MemRvalid` outside RESP is ignored. `MemGnt` outside REQ is ignored.
- **Reset (`RST` low), including mid-transaction:**
  - Go to IDLE at once.
  - All outputs 0: `Stall`, `Wdata`, `WdataValid`, `Misalign`, `BusErr`, `MemReq`, `MemWe`, `MemAdr`, `MemBe`, `MemWdata`.
  - A late response after reset is dropped.

## Timing
- All outputs except `Stall` are registered.
- **Store, zero-wait grant:** accept at cycle 0, `MemReq` in cycle 1 with `MemGnt` in cycle 1, DONE in cycle 2. `Stall` is high in cycles 0–1.
- **Load, grant in cycle 1 and `MemRvalid` in cycle 2:** `WdataValid` and `Wdata` in cycle 3. `Stall` is high in cycles 0–2.
- Each wait cycle on `MemGnt` or `MemRvalid` adds exactly one cycle.
- **Timeout:** `BusErr` is asserted in the cycle after the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after grant. `Stall` drops in that same cycle.
- Back-to-back: a new instruction is accepted in the cycle DONE returns to IDLE, so there are at most 1 access per 3 cycles.

## Structure
- Add opcode constants `LB`=6'h20, `LH`=6'h21, `LBU`=6'h24, `LHU`=6'h25, `SB`=6'h28 and `SH`=6'h29 to `common_param.vh`, alongside the existing `LW` and `SW`.
- The state encoding is local to this block.
- One natural sub-module, `lsu_align`: purely combinational. Takes the opcode, `Adr[1:0]`, `Rdata2` and `MemRdata`; produces `MemBe`, `MemWdata`, the extended load data and the misalign flag. It is unit-testable in isolation.

## Test plan
- SB at `Result`=0x13, `Rdata2`=0xAABBCCDD, `MemGnt` immediate -> `MemAdr`=0x10, `MemBe`=4'b1000, `MemWdata`=0xDDDDDDDD, `MemWe`=1; `Stall` high for exactly 2 cycles.
- LB at 0x21, `MemRdata`=0x0000_8000 -> `Wdata`=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x22 with `MemRdata`=0xF00D_0000 -> 0x0000F00D.
- LW at 0x40 with `MemGnt` delayed 3 cycles and `MemRvalid` delayed 2 more -> `MemReq` held with stable fields, `WdataValid` one pulse, total `Stall` = 6 cycles.
- LW at 0x42 and SH at 0x41 -> no `MemReq`, `Misalign` pulses once each, `Stall` stays 0.
- Load with `MemRvalid` never returned, `TIMEOUT`=4 -> `BusErr` one pulse, `Wdata`=0, FSM back in IDLE; the next SW completes normally.
- `RST` low while in RESP, then `MemRvalid` arrives -> all outputs 0; no `WdataValid` after reset release.
